// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings used by fetch/decode and the
// fetch-stage FSM state encoding.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 5;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_B    = 5'b10001;
    localparam opcode_t OP_BEQ  = 5'b10010;
    localparam opcode_t OP_JMP  = 5'b10011;
    localparam opcode_t OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a fetch response that arrives
// while IF/ID is stalled.
// Ports: load_i writes instr_i/pc_i, unload_i empties, flush_i empties with
// priority over both; full_o/instr_o/pc_o expose the stored entry.
module fetch_skid_buf #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               unload_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               full_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               full_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q  <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (unload_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time, and presents fetched words to decode through the IF/ID register.
// Ports: imem_* req/gnt/rvalid memory interface; id_stall holds IF/ID;
// redirect/redirect_pc flush and refetch; if_* IF/ID contents (if_opcode is
// the combinational top slice of if_instr); halted flags a fetched HALT.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [4:0]         if_opcode,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_next,
    output logic               halted
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ifv_q;
    logic [INSTR_W-1:0] ifi_q;
    logic [ADDR_W-1:0]  ifpc_q, ifpcn_q;
    logic               halted_q;

    logic               gnt_acc, rsp_take, ifid_free;
    logic               ifid_load_rsp, ifid_load_skid, ifid_clear;
    logic               skid_load, skid_unload, skid_flush, skid_full_next;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    opcode_t            rsp_opcode;

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (skid_flush),
        .instr_i  (imem_rdata),
        .pc_i     (req_pc_q),
        .full_o   (skid_full),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    assign gnt_acc    = req_q & imem_gnt;
    assign rsp_take   = (state_q == WAIT_RSP) & imem_rvalid;
    assign ifid_free  = ~ifv_q | ~id_stall;
    assign rsp_opcode = imem_rdata[INSTR_W-1 -: OPCODE_W];

    // Next-state, PC, IF/ID and skid control
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        ifid_load_rsp  = 1'b0;
        ifid_load_skid = 1'b0;
        ifid_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        skid_flush     = 1'b0;

        if (redirect) begin
            pc_d       = redirect_pc;
            skid_flush = 1'b1;
            ifid_clear = 1'b1;
            case (state_q)
                REQ:             state_d = gnt_acc ? DRAIN : REQ;
                // A response landing together with the redirect is dropped
                // here, so there is nothing left to drain.
                WAIT_RSP, DRAIN: state_d = imem_rvalid ? REQ : DRAIN;
                HALTED:          state_d = REQ;
                default:         state_d = REQ;
            endcase
        end else begin
            if (!id_stall) begin
                if (skid_full) begin
                    ifid_load_skid = 1'b1;
                    skid_unload    = 1'b1;
                end else if (rsp_take) begin
                    ifid_load_rsp = 1'b1;
                end else begin
                    ifid_clear = 1'b1;
                end
            end else if (rsp_take && !ifv_q) begin
                ifid_load_rsp = 1'b1;
            end
            skid_load = rsp_take & ~ifid_free;

            case (state_q)
                REQ: begin
                    if (gnt_acc) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + ADDR_W'(1);
                        state_d  = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (imem_rvalid) begin
                        state_d = (rsp_opcode == OP_HALT) ? HALTED : REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = REQ;
                    end
                end
                HALTED:  state_d = HALTED;
                default: state_d = REQ;
            endcase
        end

        // Request only when the skid can absorb a stalled response.
        skid_full_next = skid_load | (skid_full & ~skid_unload & ~skid_flush);
        req_d          = (state_d == REQ) & ~skid_full_next;
        addr_d         = pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            ifv_q    <= 1'b0;
            ifi_q    <= '0;
            ifpc_q   <= '0;
            ifpcn_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            halted_q <= (state_d == HALTED);
            if (ifid_load_skid) begin
                ifv_q   <= 1'b1;
                ifi_q   <= skid_instr;
                ifpc_q  <= skid_pc;
                ifpcn_q <= skid_pc + ADDR_W'(1);
            end else if (ifid_load_rsp) begin
                ifv_q   <= 1'b1;
                ifi_q   <= imem_rdata;
                ifpc_q  <= req_pc_q;
                ifpcn_q <= req_pc_q + ADDR_W'(1);
            end else if (ifid_clear) begin
                ifv_q <= 1'b0;
            end
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign if_valid   = ifv_q;
    assign if_instr   = ifi_q;
    assign if_opcode  = ifi_q[INSTR_W-1 -: OPCODE_W];
    assign if_pc      = ifpc_q;
    assign if_pc_next = ifpcn_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle-latency, always-granting
// instruction memory model. Outputs sampled and inputs driven on negedge.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [4:0]  if_opcode;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;
    logic        halted;

    logic        halt_en;
    logic [15:0] halt_addr;
    int          checks   = 0;
    int          failures = 0;

    instr_fetch #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc       (if_pc),
        .if_pc_next  (if_pc_next),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Memory contents: opcode 00001 with the low address bits, or HALT at halt_addr.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_en && a == halt_addr) return 16'hF800;
        return {5'b00001, a[10:0]};
    endfunction

    // Memory responds exactly one cycle after a granted request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= imem_req && imem_gnt;
            imem_rdata  <= mem_word(imem_addr);
        end
    end

    task automatic wait_ifpc(input logic [15:0] pc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (if_valid && if_pc == pc) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_req(input logic [15:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; halt_en = 1'b0; halt_addr = '0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin $display("FAIL rst_req got=%b exp=0", imem_req); failures++; end
        checks++; if (if_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", if_valid); failures++; end
        checks++; if (if_pc !== 16'h0) begin $display("FAIL rst_pc got=%h exp=0000", if_pc); failures++; end
        checks++; if (if_instr !== 16'h0) begin $display("FAIL rst_instr got=%h exp=0000", if_instr); failures++; end
        checks++; if (halted !== 1'b0) begin $display("FAIL rst_halted got=%b exp=0", halted); failures++; end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin $display("FAIL seq_req0 got=%b/%h exp=1/0000", imem_req, imem_addr); failures++; end
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin $display("FAIL seq_wait got req=%b valid=%b exp=0/0", imem_req, if_valid); failures++; end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0 || if_pc_next !== 16'h1) begin $display("FAIL seq_if0 got=%b/%h/%h exp=1/0000/0001", if_valid, if_pc, if_pc_next); failures++; end
        checks++; if (if_instr !== 16'h0800 || if_opcode !== 5'b00001) begin $display("FAIL seq_instr0 got=%h/%b exp=0800/00001", if_instr, if_opcode); failures++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h1) begin $display("FAIL seq_req1 got=%b/%h exp=1/0001", imem_req, imem_addr); failures++; end
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin $display("FAIL seq_bubble got=%b exp=0", if_valid); failures++; end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h1 || if_pc_next !== 16'h2) begin $display("FAIL seq_if1 got=%b/%h/%h exp=1/0001/0002", if_valid, if_pc, if_pc_next); failures++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h2) begin $display("FAIL seq_req2 got=%b/%h exp=1/0002", imem_req, imem_addr); failures++; end
        repeat (2) @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h2 || if_pc_next !== 16'h3) begin $display("FAIL seq_if2 got=%b/%h/%h exp=1/0002/0003", if_valid, if_pc, if_pc_next); failures++; end
    endtask

    task automatic test_stall;
        bit ok;
        wait_ifpc(16'h5, ok);
        checks++; if (!ok) begin $display("FAIL stall_reach5 got=timeout exp=if_pc 0005"); failures++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h6) begin $display("FAIL stall_req6 got=%b/%h exp=1/0006", imem_req, imem_addr); failures++; end
        id_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || if_pc !== 16'h5) begin $display("FAIL stall_hold%0d got=%b/%h exp=1/0005", i, if_valid, if_pc); failures++; end
            checks++; if (imem_req !== 1'b0) begin $display("FAIL stall_noreq%0d got=%b exp=0", i, imem_req); failures++; end
        end
        id_stall = 1'b0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h6 || if_instr !== 16'h0806) begin $display("FAIL stall_skid got=%b/%h/%h exp=1/0006/0806", if_valid, if_pc, if_instr); failures++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h7) begin $display("FAIL stall_req7 got=%b/%h exp=1/0007", imem_req, imem_addr); failures++; end
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin $display("FAIL stall_after got=%b exp=0", if_valid); failures++; end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h7) begin $display("FAIL stall_if7 got=%b/%h exp=1/0007", if_valid, if_pc); failures++; end
    endtask

    task automatic test_redirect_wait;
        bit ok;
        wait_req(16'h9, ok);
        checks++; if (!ok) begin $display("FAIL redir_reach9 got=timeout exp=req 0009"); failures++; end
        @(negedge clk);
        checks++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin $display("FAIL redir_inwait got rvalid=%b req=%b exp=1/0", imem_rvalid, imem_req); failures++; end
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin $display("FAIL redir_flush got=%b exp=0", if_valid); failures++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin $display("FAIL redir_req got=%b/%h exp=1/0040", imem_req, imem_addr); failures++; end
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin $display("FAIL redir_no9 got=%b/%h exp=0", if_valid, if_pc); failures++; end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0040) begin $display("FAIL redir_if40 got=%b/%h exp=1/0040", if_valid, if_pc); failures++; end
    endtask

    task automatic test_redirect_stall;
        checks++; if (if_valid !== 1'b1 || imem_req !== 1'b1) begin $display("FAIL rs_setup got valid=%b req=%b exp=1/1", if_valid, imem_req); failures++; end
        redirect = 1'b1; id_stall = 1'b1; redirect_pc = 16'h0080;
        @(negedge clk);
        redirect = 1'b0; id_stall = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin $display("FAIL rs_flush got valid=%b req=%b exp=0/0", if_valid, imem_req); failures++; end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080 || if_valid !== 1'b0) begin $display("FAIL rs_drain got=%b/%h valid=%b exp=1/0080/0", imem_req, imem_addr, if_valid); failures++; end
        repeat (2) @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0080) begin $display("FAIL rs_if80 got=%b/%h exp=1/0080", if_valid, if_pc); failures++; end
    endtask

    task automatic test_pc_wrap;
        bit ok;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        wait_req(16'hFFFF, ok);
        checks++; if (!ok) begin $display("FAIL wrap_reqffff got=timeout exp=req ffff"); failures++; end
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin $display("FAIL wrap_req0 got=%b/%h exp=1/0000", imem_req, imem_addr); failures++; end
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFF || if_pc_next !== 16'h0000) begin $display("FAIL wrap_ifpc got=%b/%h/%h exp=1/ffff/0000", if_valid, if_pc, if_pc_next); failures++; end
    endtask

    task automatic test_halt;
        bit ok;
        halt_en = 1'b1; halt_addr = 16'h0003;
        redirect = 1'b1; redirect_pc = 16'h0003;
        @(negedge clk);
        redirect = 1'b0;
        wait_ifpc(16'h0003, ok);
        checks++; if (!ok) begin $display("FAIL halt_reach3 got=timeout exp=if_pc 0003"); failures++; end
        checks++; if (halted !== 1'b1 || if_opcode !== 5'b11111 || imem_req !== 1'b0) begin $display("FAIL halt_set got halted=%b op=%b req=%b exp=1/11111/0", halted, if_opcode, imem_req); failures++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || halted !== 1'b1) begin $display("FAIL halt_hold%0d got req=%b halted=%b exp=0/1", i, imem_req, halted); failures++; end
        end
        redirect = 1'b1; redirect_pc = 16'h0010;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin $display("FAIL halt_exit got halted=%b req=%b addr=%h exp=0/1/0010", halted, imem_req, imem_addr); failures++; end
        repeat (2) @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0010 || halted !== 1'b0) begin $display("FAIL halt_if10 got=%b/%h halted=%b exp=1/0010/0", if_valid, if_pc, halted); failures++; end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_pc_wrap();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage directly upstream of the control decoder. It owns the PC, requests instruction words from the instruction memory over a req/gnt/rvalid interface with one request outstanding at a time, and presents fetched words to decode in an IF/ID output register. The 5-bit opcode slice of that register feeds the decoder. It accepts decode back-pressure (stall) and taken branch/jump redirects from downstream.

Parameters:
ADDR_W, 16, PC and memory address width (word-addressed)
INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1 -: 5]
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address; held stable while imem_req && !imem_gnt
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; at least 1 cycle after gnt
imem_rdata  in  INSTR_W  response word
id_stall  in  1  decode cannot accept; hold IF/ID contents
redirect  in  1  taken B/BEQ/JMP; flush and refetch
redirect_pc  in  ADDR_W  redirect target
if_valid  out  1  IF/ID register holds a valid instruction
if_instr  out  INSTR_W  IF/ID instruction
if_opcode  out  5  if_instr top 5 bits, to decoder
if_pc  out  ADDR_W  address of if_instr
if_pc_next  out  ADDR_W  if_pc + 1, modulo 2^ADDR_W
halted  out  1  HALT opcode fetched; fetch stopped

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, imem_req=0 while in reset, if_valid=0, if_instr=0, if_pc=0, skid empty, halted=0. First request is issued in the first cycle after rst_n rises.
- States: REQ, WAIT_RSP, DRAIN, HALTED.
- REQ: imem_req=1, imem_addr=pc only if the skid buffer is empty; otherwise imem_req=0. On gnt: latch req_pc=pc, pc<=pc+1 (wraps from 2^ADDR_W-1 to 0), go to WAIT_RSP.
- WAIT_RSP: imem_req=0. On rvalid: if IF/ID is free (!if_valid || !id_stall), load IF/ID with {rdata, req_pc}, if_valid=1. Otherwise write the skid buffer. Next state is HALTED if rdata opcode == OP_HALT, else REQ.
- IF/ID update: when !id_stall, IF/ID loads from the skid if the skid is full (skid is then emptied), else from a same-cycle response, else if_valid<=0. When id_stall=1, IF/ID and the skid hold.
- Latency: response to if_valid is 1 cycle (registered). Best-case throughput is 1 instruction per 2 cycles with 1-cycle memory latency.
- Redirect has priority over stall and over every other event. Next cycle: pc=redirect_pc, if_valid=0, skid emptied, halted=0.
  - In WAIT_RSP, or in REQ with gnt in the same cycle: go to DRAIN.
  - In REQ without gnt: stay in REQ; the new address may replace the un-granted one.
  - In HALTED or DRAIN: go to REQ / stay in DRAIN respectively.
- DRAIN: imem_req=0. The outstanding response is discarded on rvalid, then go to REQ. A rvalid coincident with a redirect in WAIT_RSP is discarded.
- HALTED: halted=1, imem_req=0. The HALT word is still presented on IF/ID. Only redirect or reset leaves this state.
- Reset mid-transaction: all state is cleared. The memory is required to drop outstanding responses on its own reset, which shares rst_n.
- if_opcode is combinational from if_instr. All other outputs are registered.

Decomposition:
- Shared package cpu_pkg: opcode_t (5-bit), OP_B=5'b10001, OP_BEQ=5'b10010, OP_JMP=5'b10011, OP_HALT=5'b11111, fetch_state_t enum {REQ, WAIT_RSP, DRAIN, HALTED}.
- One sub-module: fetch_skid_buf, a one-entry {instr, pc} buffer with load/unload/flush.
- The PC and FSM remain in instr_fetch.

Test Plan:
- Reset release, imem always grants, rvalid 1 cycle after gnt, id_stall=0 -> imem_addr 0,1,2 issued; if_valid pulses with if_pc=0,1,2 and if_pc_next=1,2,3.
- id_stall=1 for 4 cycles while IF/ID holds pc=5 and the pc=6 response arrives -> IF/ID holds pc=5, pc=6 goes to skid, imem_req=0. Stall drops -> pc=6 on the next cycle, then the request for 7 is issued.
- redirect=1, redirect_pc=0x0040 in WAIT_RSP for pc=9 -> the pc=9 response is discarded, if_valid=0; the next imem_addr is 0x0040 and if_pc=0x0040.
- redirect and id_stall asserted together with valid IF/ID -> the flush wins: if_valid=0 next cycle.
- PC at 0xFFFF fetched -> the next request address is 0x0000.
- Fetch rdata with opcode 11111 at pc=3 -> halted=1, imem_req stays 0 for 10 cycles. Then redirect to 0x0010 -> halted=0 and a fetch at 0x0010.
